// File: rtl/bu_lower_sched_if.sv
// Requester-side bundle for bu_lower_sched: operation requests with one-hot
// grant, plus the tagged result strobe returned to the requesters.
interface bu_lower_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [32*NUM_REQ-1:0] req_d;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic [3:0]            rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_d,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_d,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );
endinterface

// File: rtl/bu_lower_sched.sv
// Round-robin scheduler sharing one bu_lower (a-b)/d unit among NUM_REQ
// requesters; in-flight requester IDs ride a shift pipe matched to the unit.
module bu_lower_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = 13
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        enable,
    bu_lower_sched_if.slave sif,
    output logic [31:0] bu_data_a_sum,
    output logic [31:0] bu_data_b_sum,
    output logic [31:0] bu_datab_div,
    output logic        bu_data_in_flag,
    output logic        bu_clk_en,
    input  logic [31:0] bu_result,
    input  logic        bu_data_available,
    input  logic [3:0]  bu_flags,
    output logic        busy,
    output logic        seq_error
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = $clog2(LATENCY + 2);

    logic [ID_W-1:0]              rr_ptr;
    logic [ID_W-1:0]              issue_id;
    logic [NUM_REQ-1:0]           grant;
    logic                         grant_any;
    logic [IW-1:0]                gidx;
    logic [IW-1:0]                cand;
    logic [LATENCY-1:0]           trk_v;
    logic [LATENCY-1:0][ID_W-1:0] trk_id;
    logic [GW-1:0]                guard;

    // Scan starts one past the last winner, so a busy requester yields.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        gidx      = '0;
        cand      = '0;
        if (enable) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = IW'((32'(rr_ptr) + k) % NUM_REQ);
                if (!grant_any && sif.req_valid[cand]) begin
                    grant[cand] = 1'b1;
                    gidx        = cand;
                    grant_any   = 1'b1;
                end
            end
        end
    end

    assign sif.req_ready = grant;
    assign bu_clk_en     = 1'b1;
    assign busy          = bu_data_in_flag | (|trk_v) | sif.rsp_valid;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            rr_ptr          <= ID_W'(NUM_REQ - 1);
            issue_id        <= '0;
            bu_data_a_sum   <= '0;
            bu_data_b_sum   <= '0;
            bu_datab_div    <= '0;
            bu_data_in_flag <= 1'b0;
            trk_v           <= '0;
            trk_id          <= '0;
            sif.rsp_valid   <= 1'b0;
            sif.rsp_id      <= '0;
            sif.rsp_result  <= '0;
            sif.rsp_flags   <= '0;
            seq_error       <= 1'b0;
            guard           <= '0;
        end else begin
            bu_data_in_flag <= grant_any;
            if (grant_any) begin
                rr_ptr        <= ID_W'(gidx);
                issue_id      <= ID_W'(gidx);
                bu_data_a_sum <= sif.req_a[{gidx, 5'd0} +: 32];
                bu_data_b_sum <= sif.req_b[{gidx, 5'd0} +: 32];
                bu_datab_div  <= sif.req_d[{gidx, 5'd0} +: 32];
            end

            // Never stalls: the unit's own valid shifter runs regardless of clk_en.
            trk_v  <= {trk_v[LATENCY-2:0], bu_data_in_flag};
            trk_id <= {trk_id[LATENCY-2:0], issue_id};

            sif.rsp_valid <= trk_v[LATENCY-1];
            if (trk_v[LATENCY-1]) begin
                sif.rsp_id     <= trk_id[LATENCY-1];
                sif.rsp_result <= bu_result;
                sif.rsp_flags  <= bu_flags;
            end

            // Unit strobes left over from before aclr are not flagged until the guard saturates.
            if (guard != GW'(LATENCY + 1)) begin
                guard <= guard + 1'b1;
            end else if (bu_data_available != trk_v[LATENCY-1]) begin
                seq_error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bu_lower_sched.sv
// Self-checking bench for bu_lower_sched with a behavioural bu_lower stand-in
// and a queue-based scoreboard of expected grants and tagged responses.
module tb_bu_lower_sched;
    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int LAT = 13;

    logic clock  = 1'b0;
    logic aclr   = 1'b0;
    logic enable = 1'b0;
    always #5 clock = ~clock;

    bu_lower_sched_if #(.NUM_REQ(NR), .ID_W(IDW)) sif ();

    logic [31:0] bu_a, bu_b, bu_d, bu_result;
    logic        bu_in_flag, bu_clk_en, bu_avail, busy, seq_error;
    logic [3:0]  bu_flags;
    logic        force_avail = 1'b0;

    bu_lower_sched #(.NUM_REQ(NR), .ID_W(IDW), .LATENCY(LAT)) dut (
        .clock(clock), .aclr(aclr), .enable(enable), .sif(sif),
        .bu_data_a_sum(bu_a), .bu_data_b_sum(bu_b), .bu_datab_div(bu_d),
        .bu_data_in_flag(bu_in_flag), .bu_clk_en(bu_clk_en),
        .bu_result(bu_result), .bu_data_available(bu_avail), .bu_flags(bu_flags),
        .busy(busy), .seq_error(seq_error)
    );

    function automatic real f2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] bb;
        logic [10:0] e;
        bb = $realtobits(r);
        if (bb[62:0] == 63'd0) return {bb[63], 31'd0};
        e = bb[62:52] - 11'd896;
        return {bb[63], e[7:0], bb[51:29]};
    endfunction

    // {flags, result}; flags = {zero, overflow, underflow, division_by_zero}
    function automatic logic [35:0] unit_f(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] d);
        real ra, rb, rd;
        logic [31:0] res;
        ra = f2r(a); rb = f2r(b); rd = f2r(d);
        if (d[30:0] == 31'd0) return {4'b0001, (ra < rb) ^ d[31], 8'hFF, 23'd0};
        res = r2f((ra - rb) / rd);
        return {(res[30:0] == 31'd0), 3'b000, res};
    endfunction

    // Stand-in unit: fixed LATENCY pipe whose valid shifter ignores aclr.
    logic [LAT-1:0] u_v = '0;
    logic [35:0]    u_d [LAT];
    initial for (int i = 0; i < LAT; i++) u_d[i] = '0;
    always @(posedge clock) begin
        u_v <= {u_v[LAT-2:0], bu_in_flag};
        for (int i = LAT - 1; i > 0; i--) u_d[i] <= u_d[i-1];
        u_d[0] <= unit_f(bu_a, bu_b, bu_d);
    end
    assign bu_avail             = u_v[LAT-1] | force_avail;
    assign {bu_flags, bu_result} = u_d[LAT-1];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  fl;
        int          iss;
        int          due;
    } exp_t;
    exp_t q[$];
    int   mrr     = NR - 1;
    bit   chk_seq = 1'b1;

    always @(negedge clock) begin
        exp_t        e;
        logic [35:0] r;
        logic [NR-1:0] eg;
        int          gi;
        bit          eb;
        if (aclr) begin
            q.delete();
            mrr = NR - 1;
        end else begin
            eb = 1'b0;
            foreach (q[i]) if (q[i].iss < cyc) eb = 1'b1;
            chk("busy", busy, eb);
            if (chk_seq) chk("seq_error", seq_error, 0);
            if (sif.rsp_valid) begin
                if (q.size() == 0) chk("rsp_spurious", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rsp_cycle", cyc, e.due);
                    chk("rsp_id", sif.rsp_id, e.id);
                    chk("rsp_result", sif.rsp_result, e.res);
                    chk("rsp_flags", sif.rsp_flags, e.fl);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("rsp_missing", 0, 1);
            end
            eg = '0;
            gi = -1;
            if (enable) begin
                for (int k = 1; k <= NR; k++) begin
                    if (sif.req_valid[(mrr + k) % NR]) begin
                        gi = (mrr + k) % NR;
                        break;
                    end
                end
            end
            if (gi >= 0) eg[gi] = 1'b1;
            chk("grant", sif.req_ready, eg);
            if (gi >= 0) begin
                r     = unit_f(sif.req_a[32*gi +: 32], sif.req_b[32*gi +: 32], sif.req_d[32*gi +: 32]);
                e.id  = gi;
                e.res = r[31:0];
                e.fl  = r[35:32];
                e.iss = cyc;
                e.due = cyc + LAT + 2;
                q.push_back(e);
                mrr = gi;
            end
        end
    end

    typedef struct {
        int          id;
        logic [31:0] a, b, d;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;
    vec_t vecs[4];

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] d);
        sif.req_a[32*id +: 32] = a;
        sif.req_b[32*id +: 32] = b;
        sif.req_d[32*id +: 32] = d;
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1 aclr = 1'b1;
        @(posedge clock); #1 aclr = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int t0, n;
        @(posedge clock); #1;
        set_op(v.id, v.a, v.b, v.d);
        sif.req_valid = '0;
        sif.req_valid[v.id] = 1'b1;
        @(negedge clock);
        chk("op_grant", sif.req_ready, 32'd1 << v.id);
        t0 = cyc;
        @(posedge clock); #1 sif.req_valid = '0;
        n = 0;
        for (int w = 0; w < 30; w++) begin
            @(negedge clock);
            if (sif.rsp_valid) begin
                n++;
                chk("op_latency", cyc - t0, LAT + 2);
                chk("op_id", sif.rsp_id, v.id);
                chk("op_result", sif.rsp_result, v.res);
                chk("op_flags", sif.rsp_flags, v.fl);
            end
        end
        chk("op_rsp_count", n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int first;
        vecs[0] = '{2, 32'h40A00000, 32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000};
        vecs[1] = '{1, 32'h40400000, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001};
        vecs[2] = '{0, 32'h40400000, 32'h40400000, 32'h3F800000, 32'h00000000, 4'b1000};
        vecs[3] = '{3, 32'h41200000, 32'h40800000, 32'h40800000, 32'h3FC00000, 4'b0000};

        sif.req_valid = '0;
        sif.req_a = '0; sif.req_b = '0; sif.req_d = '0;
        #1 aclr = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_flag", bu_in_flag, 0);
        chk("rst_rsp_valid", sif.rsp_valid, 0);
        chk("rst_rsp_id", sif.rsp_id, 0);
        chk("rst_rsp_result", sif.rsp_result, 0);
        chk("rst_rsp_flags", sif.rsp_flags, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq_error", seq_error, 0);
        chk("rst_operand_a", bu_a, 0);
        chk("clk_en", bu_clk_en, 1);
        @(posedge clock); #1 aclr = 1'b0; enable = 1'b1;

        // Contention: all four requesters for eight cycles
        for (int i = 0; i < NR; i++) set_op(i, r2f(real'(i + 6)), r2f(real'(i)), r2f(2.0));
        for (int k = 0; k < 8; k++) begin
            sif.req_valid = '1;
            @(negedge clock);
            chk("cont_grant", sif.req_ready, 32'd1 << (k % NR));
            @(posedge clock); #1;
        end
        sif.req_valid = '0;
        found = 1'b0;
        for (int w = 0; w < 30 && !found; w++) begin
            @(negedge clock);
            if (sif.rsp_valid) found = 1'b1;
        end
        chk("cont_rsp_seen", found, 1);
        for (int k = 0; k < 8; k++) begin
            chk("cont_rsp_valid", sif.rsp_valid, 1);
            chk("cont_rsp_id", sif.rsp_id, k % NR);
            @(negedge clock);
        end
        chk("cont_rsp_end", sif.rsp_valid, 0);
        chk("cont_busy_drop", busy, 0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Disabled issue, then first grant follows the round-robin pointer
        @(posedge clock); #1 enable = 1'b0; sif.req_valid = '1;
        repeat (3) begin
            @(negedge clock);
            chk("dis_ready", sif.req_ready, 0);
            chk("dis_in_flag", bu_in_flag, 0);
            @(posedge clock); #1;
        end
        first = (mrr + 1) % NR;
        enable = 1'b1;
        @(negedge clock);
        chk("en_first_grant", sif.req_ready, 32'd1 << first);
        @(posedge clock); #1 sif.req_valid = '0;
        repeat (20) @(posedge clock);

        // Reset with three operations in flight
        #1 sif.req_valid = 4'b0111;
        repeat (3) @(posedge clock);
        #1 sif.req_valid = '0;
        repeat (4) @(posedge clock);
        pulse_reset();
        for (int w = 0; w < 25; w++) begin
            @(negedge clock);
            chk("rst_mid_rsp", sif.rsp_valid, 0);
            chk("rst_mid_seq", seq_error, 0);
        end
        run_op(vecs[0]);

        // Forced unit strobe with an empty tracker
        pulse_reset();
        repeat (20) @(posedge clock);
        #1 chk_seq = 1'b0; force_avail = 1'b1;
        @(posedge clock); #1 force_avail = 1'b0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clock);
            chk("seq_sticky", seq_error, 1);
        end
        pulse_reset();
        @(negedge clock);
        chk("seq_cleared", seq_error, 0);
        chk_seq = 1'b1;

        // Randomized traffic against the scoreboard
        @(posedge clock); #1;
        for (int c = 0; c < 400; c++) begin
            enable = ($urandom_range(0, 7) != 0);
            sif.req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                int unsigned ds;
                ds = $urandom_range(0, 9);
                set_op(i, r2f(real'($urandom_range(0, 200))), r2f(real'($urandom_range(0, 200))),
                       (ds == 0) ? 32'h0 : r2f(real'(ds) / 2.0));
            end
            @(posedge clock); #1;
        end
        sif.req_valid = '0;
        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
